// File: rtl/uimm_exec_pipe.sv
// uimm_exec_pipe: elastic DEPTH-stage execute pipe for the U-type
// instructions LUI and AUIPC. It sits between issue and GPR writeback.
// The result is formed at stage-0 entry. Later stages only carry
// {data, rd, tag, vld} toward the writeback handshake.
// Optional build macro UIMM_EXEC_PIPE_PERF_CNT_EN adds saturating,
// read-only performance counters.
module uimm_exec_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_is_auipc,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [19:0]      req_imm20,
  input  logic [4:0]       req_rd,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             wb_vld,
  input  logic             wb_rdy,
  output logic             wb_wen,
  output logic [4:0]       wb_waddr,
  output logic [XLEN-1:0]  wb_wdata,
  output logic [TAG_W-1:0] wb_tag
`ifdef UIMM_EXEC_PIPE_PERF_CNT_EN
  ,
  output logic [63:0]      perf_retired,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flushed
`endif
);

  localparam int unsigned LAST = DEPTH - 1;

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] space;
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  result;
  logic             accept;

  // A stage can take new contents when it is empty or is handing off this cycle.
  // "valid && next-can-take" is folded into "!valid || next-can-take", which
  // gives a simple ripple from the writeback end.
  always_comb begin
    space       = '0;
    space[LAST] = !vld_q[LAST] || wb_rdy;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      space[LAST-k] = !vld_q[LAST-k] || space[LAST-k+1];
    end
  end

  assign req_rdy = !flush && space[0];
  assign accept  = req_vld && req_rdy;

  // The U-type immediate is sign-extended from bit 31. AUIPC wraps silently.
  always_comb begin
    imm32  = {req_imm20, 12'h000};
    imm    = XLEN'($signed(imm32));
    result = req_is_auipc ? (req_pc + imm) : imm;
  end

  // Pipeline registers: stage 0 captures the request, and later stages shift forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        tag_q[i]  <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      if (space[0]) begin
        vld_q[0] <= accept;
        if (accept) begin
          data_q[0] <= result;
          rd_q[0]   <= req_rd;
          tag_q[0]  <= req_tag;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (space[i]) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            data_q[i] <= data_q[i-1];
            rd_q[i]   <= rd_q[i-1];
            tag_q[i]  <= tag_q[i-1];
          end
        end
      end
    end
  end

  assign wb_vld   = vld_q[LAST];
  assign wb_waddr = rd_q[LAST];
  assign wb_wdata = data_q[LAST];
  assign wb_tag   = tag_q[LAST];
  assign wb_wen   = vld_q[LAST] && (rd_q[LAST] != '0);

`ifdef UIMM_EXEC_PIPE_PERF_CNT_EN
  logic        retire;
  logic [2:0]  live;
  logic [2:0]  dropped;
  logic [32:0] flushed_sum;

  assign retire = vld_q[LAST] && wb_rdy;

  // An entry that retires in the flush cycle is not counted as dropped.
  always_comb begin
    live = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live = live + {2'b00, vld_q[i]};
    end
    dropped     = live - {2'b00, retire};
    flushed_sum = {1'b0, perf_flushed} + {30'd0, dropped};
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (retire && (perf_retired != '1)) perf_retired <= perf_retired + 64'd1;
      if (vld_q[LAST] && !wb_rdy && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      if (flush) perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule
